transfer_receiver: RTL and testbench
====================================

TRANSFER_RECEIVER -- requirements
Module: transfer_receiver

Interface
REQ-001 SHALL provide parameter WORD_WIDTH, default 8: number of serial bits per assembled word.
REQ-002 SHALL provide parameter DEPTH, default 4: word FIFO capacity (power of two).
REQ-003 SHALL provide clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL provide rst  input  1  synchronous, active-high reset.
REQ-005 SHALL provide serialClkIn  input  1  serial bit strobe from the upstream scanner, synchronous to clk.
REQ-006 SHALL provide serialDataIn  input  1  serial data bit, valid when serialClkIn rises.
REQ-007 SHALL provide readRequest  input  1  consumer pop request.
REQ-008 SHALL provide readyForTransferOut  output  1  high when at least one FIFO slot is free; drives the scanner's transfer-ready input.
REQ-009 SHALL provide wordOut  output  WORD_WIDTH  most recently popped word.
REQ-010 SHALL provide wordValid  output  1  one-cycle pulse marking a new wordOut.
REQ-011 SHALL provide storedCount  output  log2(DEPTH)+1  number of words held in the FIFO.
REQ-012 SHALL provide overflow  output  1  sticky flag: a completed word was dropped.

Function
REQ-013 SHALL register serialClkIn each cycle; bit strobe = serialClkIn & ~previous serialClkIn.
REQ-014 On a strobe, SHALL shift serialDataIn into the assembly register MSB-first and increment a bit counter (0..WORD_WIDTH-1).
REQ-015 On the strobe carrying bit WORD_WIDTH-1, SHALL form the word {assembly[WORD_WIDTH-2:0], serialDataIn} and push it into the FIFO at that same clock edge; bit counter returns to 0.
REQ-016 A held-high serialClkIn SHALL yield exactly one strobe; a strobe SHALL not occur on the cycle following reset unless serialClkIn was 0 during reset.
REQ-017 Push while FIFO full and no simultaneous pop SHALL discard the word, leave FIFO contents and storedCount unchanged, and set overflow.
REQ-018 readRequest with storedCount>0 SHALL, at that edge, load the head word into wordOut, set wordValid=1 for exactly the next cycle, advance the read pointer, decrement storedCount.
REQ-019 readRequest with storedCount=0 SHALL be ignored: wordValid=0, wordOut held.
REQ-020 Simultaneous push and pop SHALL both succeed (including when full or when count=1), storedCount unchanged, no overflow.
REQ-021 Push into an empty FIFO with simultaneous pop SHALL not bypass; the pop is ignored per REQ-019.
REQ-022 FIFO pointers SHALL wrap modulo DEPTH; words SHALL exit in arrival order.
REQ-023 readyForTransferOut SHALL equal (storedCount < DEPTH), registered-state derived, no combinational path from inputs.
REQ-024 overflow SHALL remain set until reset.
REQ-025 serialDataIn SHALL be ignored on non-strobe cycles.

Reset
REQ-026 While rst=1, SHALL clear storedCount, pointers, bit counter, assembly register, wordOut (all zeros), wordValid, overflow; readyForTransferOut=1 the cycle after reset.
REQ-027 rst SHALL override all other inputs in the same cycle; reset mid-word SHALL discard partial bits, next strobe after reset is bit 0.
REQ-028 The previous-serialClkIn register SHALL load serialClkIn during reset (not forced to 0).

Verification
REQ-029 Reset, then 8 strobes carrying 1,0,1,0,0,1,1,0 -> storedCount=1 the cycle after the 8th strobe edge; readRequest -> wordOut=8'hA6, wordValid pulses one cycle, storedCount=0.
REQ-030 Push 4 words 8'h11,8'h22,8'h33,8'h44 -> readyForTransferOut=0, storedCount=4; push 8'h55 -> overflow=1, storedCount=4; 4 pops return 8'h11,8'h22,8'h33,8'h44 in order.
REQ-031 FIFO full, 8th strobe of 8'h77 coincides with readRequest -> wordOut=head, storedCount stays 4, overflow stays 0; later pops end with 8'h77.
REQ-032 readRequest with FIFO empty -> wordValid=0, wordOut unchanged.
REQ-033 3 strobes of a word, assert rst one cycle, then 8 strobes of 8'hC3 -> popped word 8'hC3, overflow=0.
REQ-034 serialClkIn held high 10 cycles with serialDataIn toggling -> bit counter advances exactly 1.

Source files
------------

// File: rtl/transfer_receiver.sv
// Serial-to-parallel receiver: assembles MSB-first words from a strobed bit
// stream and buffers them in a small FIFO for a consumer that pops one at a time.
module transfer_receiver #(
    parameter int WORD_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    serialClkIn,
    input  logic                    serialDataIn,
    input  logic                    readRequest,
    output logic                    readyForTransferOut,
    output logic [WORD_WIDTH-1:0]   wordOut,
    output logic                    wordValid,
    output logic [$clog2(DEPTH):0]  storedCount,
    output logic                    overflow
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int BW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

    logic                  sclk_prev_q;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [WORD_WIDTH-1:0] asm_q, asm_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [WORD_WIDTH-1:0] word_q, word_d;
    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d;
    logic [WORD_WIDTH-1:0] mem_q [DEPTH];

    logic                  strobe, last_bit, pop, full, do_write;
    logic [WORD_WIDTH-1:0] push_word;

    assign strobe    = serialClkIn & ~sclk_prev_q;
    assign last_bit  = strobe && (bit_cnt_q == BW'(WORD_WIDTH - 1));
    assign push_word = {asm_q[WORD_WIDTH-2:0], serialDataIn};
    assign full      = (count_q == CW'(DEPTH));
    assign pop       = readRequest && (count_q != '0);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_write  = last_bit && (!full || pop);

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        asm_d     = asm_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        word_d    = word_q;
        valid_d   = 1'b0;
        ovf_d     = ovf_q;

        if (strobe) begin
            asm_d     = push_word;
            bit_cnt_d = last_bit ? '0 : bit_cnt_q + 1'b1;
        end
        if (last_bit && !do_write)
            ovf_d = 1'b1;
        if (do_write)
            wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop) begin
            word_d   = mem_q[rd_ptr_q];
            valid_d  = 1'b1;
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(do_write) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        // Edge detector tracks the line even in reset so a held-high strobe never re-fires.
        sclk_prev_q <= serialClkIn;
        if (rst) begin
            bit_cnt_q <= '0;
            asm_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            asm_q     <= asm_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_write)
            mem_q[wr_ptr_q] <= push_word;
    end

    assign readyForTransferOut = (count_q < CW'(DEPTH));
    assign wordOut             = word_q;
    assign wordValid           = valid_q;
    assign storedCount         = count_q;
    assign overflow            = ovf_q;
endmodule

// File: tb/tb_transfer_receiver.sv
// Directed bench for transfer_receiver: a queue-based reference model checked
// every cycle, plus literal expectations on the key scenarios.
module tb_transfer_receiver;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0, sd = 1'b0, rr = 1'b0;
    logic       ready, wvalid, ovf;
    logic [7:0] wout;
    logic [2:0] cnt;

    int checks = 0, errors = 0;
    bit chk_en = 0;

    transfer_receiver #(.WORD_WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .serialClkIn(sclk), .serialDataIn(sd),
        .readRequest(rr), .readyForTransferOut(ready), .wordOut(wout),
        .wordValid(wvalid), .storedCount(cnt), .overflow(ovf)
    );

    always #5 clk = ~clk;

    // Reference model: words are collected bit by bit and kept in a queue.
    logic [7:0] mq[$];
    logic [7:0] acc = 0, e_word = 0;
    int         nb = 0;
    bit         m_prev = 0, e_valid = 0, e_ovf = 0;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete(); nb = 0; acc = 0; e_word = 0; e_valid = 0; e_ovf = 0;
        end else begin
            e_valid = rr && (mq.size() > 0);
            if (e_valid) e_word = mq.pop_front();
            if (sclk && !m_prev) begin
                acc = {acc[6:0], sd};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    if (mq.size() < 4) mq.push_back(acc);
                    else e_ovf = 1;
                end
            end
        end
        m_prev = sclk;
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model.count", int'(cnt), mq.size());
            check("model.ready", int'(ready), int'(mq.size() < 4));
            check("model.valid", int'(wvalid), int'(e_valid));
            check("model.word", int'(wout), int'(e_word));
            check("model.ovf", int'(ovf), int'(e_ovf));
        end
    end

    task automatic cyc(); @(negedge clk); endtask

    task automatic do_reset(input logic hold);
        rst = 1; sclk = hold; rr = 0;
        repeat (2) cyc();
        rst = 0;
    endtask

    task automatic send_bit(input logic b);
        sclk = 1; sd = b; cyc();
        sclk = 0; sd = ~b; cyc();
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic pop_expect(input string name, input logic [7:0] w);
        rr = 1; cyc(); rr = 0;
        check({name, ".word"}, int'(wout), int'(w));
        check({name, ".valid"}, int'(wvalid), 1);
    endtask

    initial begin
        logic [7:0] exp_list [4];
        do_reset(1'b0);
        chk_en = 1;
        check("reset.count", int'(cnt), 0);
        check("reset.ready", int'(ready), 1);
        check("reset.word", int'(wout), 0);
        check("reset.ovf", int'(ovf), 0);

        // Basic word assembly 1,0,1,0,0,1,1,0
        send_word(8'hA6);
        check("a6.count", int'(cnt), 1);
        pop_expect("a6", 8'hA6);
        cyc();
        check("a6.pulse_end", int'(wvalid), 0);
        check("a6.count_after", int'(cnt), 0);

        // Pop from empty FIFO is ignored
        rr = 1; cyc(); rr = 0;
        check("empty.valid", int'(wvalid), 0);
        check("empty.word", int'(wout), 8'hA6);

        // Fill, overflow, drain in order
        send_word(8'h11); send_word(8'h22); send_word(8'h33); send_word(8'h44);
        check("full.ready", int'(ready), 0);
        check("full.count", int'(cnt), 4);
        send_word(8'h55);
        check("ovf.flag", int'(ovf), 1);
        check("ovf.count", int'(cnt), 4);
        exp_list = '{8'h11, 8'h22, 8'h33, 8'h44};
        foreach (exp_list[i]) pop_expect("drain", exp_list[i]);
        check("ovf.sticky", int'(ovf), 1);

        // Push and pop together while full
        do_reset(1'b0);
        send_word(8'h10); send_word(8'h20); send_word(8'h30); send_word(8'h40);
        for (int i = 7; i >= 1; i--) send_bit(1'(8'h77 >> i));
        sclk = 1; sd = 1; rr = 1; cyc();
        sclk = 0; rr = 0;
        check("pp.word", int'(wout), 8'h10);
        check("pp.count", int'(cnt), 4);
        check("pp.ovf", int'(ovf), 0);
        cyc();
        exp_list = '{8'h20, 8'h30, 8'h40, 8'h77};
        foreach (exp_list[i]) pop_expect("pp.drain", exp_list[i]);

        // Reset mid-word discards the partial bits
        send_bit(1); send_bit(1); send_bit(1);
        rst = 1; cyc(); rst = 0;
        send_word(8'hC3);
        pop_expect("midrst", 8'hC3);
        check("midrst.ovf", int'(ovf), 0);

        // Line held high through reset must not strobe afterwards
        do_reset(1'b1);
        repeat (3) cyc();
        sclk = 0; cyc();
        check("hold.count", int'(cnt), 0);
        send_word(8'h5A);
        pop_expect("hold", 8'h5A);

        // Held-high strobe counts one bit only
        sclk = 1; sd = 1; cyc();
        for (int i = 0; i < 9; i++) begin sd = ~sd; cyc(); end
        sclk = 0; cyc();
        for (int i = 0; i < 7; i++) send_bit(1'(i % 2));
        check("held.count", int'(cnt), 1);
        pop_expect("held", 8'hAA);
        repeat (2) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
